// File: rtl/phy_scan_master_pkg.sv
// rtl/phy_scan_master_pkg.sv - Shared PHY scan chain defaults, FSM encoding and timing helpers
//
// Contents:
//   DEF_OUT_LEN    default length of the target serial load chain (bits)
//   DEF_IN_LEN     default length of the target serial capture chain (bits)
//   DEF_CAP_DELAY  default cycles from first shift cycle to first valid capture bit
//   scan_state_t   scan master FSM state encoding
//   drain_cycles() cycles the master idles the load chain while capture finishes
package phy_scan_master_pkg;

  localparam int DEF_OUT_LEN   = 163;
  localparam int DEF_IN_LEN    = 73;
  localparam int DEF_CAP_DELAY = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SNAP  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } scan_state_t;

  // Capture can outlast the load shift when the target's output delay plus
  // capture length exceeds the load length; the excess is spent in DRAIN.
  function automatic int drain_cycles(int out_len, int in_len, int cap_delay);
    int d;
    d = cap_delay + in_len - out_len;
    return (d > 0) ? d : 0;
  endfunction

endpackage

// File: rtl/phy_scan_master_if.sv
// rtl/phy_scan_master_if.sv - Host-side request/response bundle of the PHY scan master
//
// Signals:
//   start    requester -> master  transaction request, honoured only while ready=1
//   tx_data  requester -> master  OUT_LEN-bit image to load, latched on accept
//   ready    master -> requester  idle, able to accept start
//   done     master -> requester  single-cycle completion pulse
//   rx_data  master -> requester  IN_LEN-bit captured image, valid from done
// Modports: master (requester side), slave (scan master side).
interface phy_scan_master_if
  import phy_scan_master_pkg::*;
#(
  parameter int OUT_LEN = DEF_OUT_LEN,
  parameter int IN_LEN  = DEF_IN_LEN
) ();

  logic               start;
  logic [OUT_LEN-1:0] tx_data;
  logic               ready;
  logic               done;
  logic [IN_LEN-1:0]  rx_data;

  modport master (
    output start,
    output tx_data,
    input  ready,
    input  done,
    input  rx_data
  );

  modport slave (
    input  start,
    input  tx_data,
    output ready,
    output done,
    output rx_data
  );

endinterface

// File: rtl/phy_scan_master_capture.sv
// rtl/phy_scan_master_capture.sv - Capture-chain deserializer for the PHY scan master
//
// Ports:
//   mclk       clock, rising edge
//   rst_in     asynchronous active-low reset
//   sample_en  shift sdin into the deserializer this cycle
//   sdin       serial capture bit from the target, MSB first
//   commit     publish the deserialized image (including a bit sampled this cycle)
//   rx_data    published image, changes only on commit
module phy_scan_master_capture
  import phy_scan_master_pkg::*;
#(
  parameter int IN_LEN = DEF_IN_LEN
) (
  input  logic              mclk,
  input  logic              rst_in,
  input  logic              sample_en,
  input  logic              sdin,
  input  logic              commit,
  output logic [IN_LEN-1:0] rx_data
);

  logic [IN_LEN-1:0] shreg;
  logic [IN_LEN-1:0] shreg_next;

  // Shift toward the MSB so the first bit taken ends up in rx_data[IN_LEN-1].
  // The cast drops the bit pushed out of the top and keeps IN_LEN=1 legal.
  always_comb begin
    shreg_next = shreg;
    if (sample_en) begin
      shreg_next = IN_LEN'({shreg, sdin});
    end
  end

  // The final sample and the commit can fall on the same edge, so the
  // published image is taken from shreg_next rather than shreg.
  always_ff @(posedge mclk or negedge rst_in) begin
    if (!rst_in) begin
      shreg   <= '0;
      rx_data <= '0;
    end else begin
      shreg <= shreg_next;
      if (commit) begin
        rx_data <= shreg_next;
      end
    end
  end

endmodule

// File: rtl/phy_scan_master.sv
// rtl/phy_scan_master.sv - Serial scan master: snapshots, loads and captures the PHY scan chains
//
// Ports:
//   mclk       single clock, rising edge
//   rst_in     asynchronous active-low reset
//   host       phy_scan_master_if.slave: start/tx_data in, ready/done/rx_data out
//   fake_din   serial load data to the target, LSB of tx_data first (flop)
//   fake_en    target shift enable (flop)
//   fake_oe    0 = target parallel snapshot, 1 = capture chain shifts/holds (flop)
//   fake_dout  serial capture data from the target, MSB first
// Parameters:
//   OUT_LEN    load chain length, IN_LEN capture chain length (OUT_LEN >= IN_LEN),
//   CAP_DELAY  cycles from the first shift cycle to the first valid fake_dout
module phy_scan_master
  import phy_scan_master_pkg::*;
#(
  parameter int OUT_LEN   = DEF_OUT_LEN,
  parameter int IN_LEN    = DEF_IN_LEN,
  parameter int CAP_DELAY = DEF_CAP_DELAY
) (
  input  logic             mclk,
  input  logic             rst_in,
  phy_scan_master_if.slave host,
  output logic             fake_din,
  output logic             fake_en,
  output logic             fake_oe,
  input  logic             fake_dout
);

  if (OUT_LEN < IN_LEN) begin : g_len_check
    $error("phy_scan_master: OUT_LEN must be >= IN_LEN");
  end
  if (IN_LEN < 1 || CAP_DELAY < 0) begin : g_param_check
    $error("phy_scan_master: IN_LEN must be >= 1 and CAP_DELAY >= 0");
  end

  // The counter spans the whole SHIFT+DRAIN window without wrapping; the
  // last used value is at most OUT_LEN+CAP_DELAY-1.
  localparam int CW            = $clog2(OUT_LEN + CAP_DELAY + 1);
  localparam int LAST_SAMPLE_I = CAP_DELAY + IN_LEN - 1;
  localparam logic [CW-1:0] LAST_SHIFT  = CW'(OUT_LEN - 1);
  localparam logic [CW-1:0] LAST_SAMPLE = CW'(LAST_SAMPLE_I);
  localparam bit NEED_DRAIN = drain_cycles(OUT_LEN, IN_LEN, CAP_DELAY) > 0;

  scan_state_t        state;
  scan_state_t        state_next;
  logic [CW-1:0]      cnt;
  logic [OUT_LEN-1:0] shadow;
  logic               shifting;
  logic               sample_en;
  logic               commit;
  logic [IN_LEN-1:0]  rx_q;

  assign shifting   = (state == ST_SHIFT) || (state == ST_DRAIN);
  assign host.ready = (state == ST_IDLE);
  assign host.done  = (state == ST_DONE);
  assign host.rx_data = rx_q;

  // cnt is the number of cycles since the first SHIFT cycle, so the capture
  // window is a fixed range of counter values.
  assign sample_en = shifting && (int'(cnt) >= CAP_DELAY) && (int'(cnt) <= LAST_SAMPLE_I);
  assign commit    = (state_next == ST_DONE);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (host.start) state_next = ST_SNAP;
      ST_SNAP:  state_next = ST_SHIFT;
      ST_SHIFT: if (cnt == LAST_SHIFT) state_next = NEED_DRAIN ? ST_DRAIN : ST_DONE;
      ST_DRAIN: if (cnt == LAST_SAMPLE) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Target-facing pins are registered from state_next so they line up with
  // the state they belong to while never depending combinationally on inputs.
  always_ff @(posedge mclk or negedge rst_in) begin
    if (!rst_in) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      shadow   <= '0;
      fake_din <= 1'b0;
      fake_en  <= 1'b0;
      fake_oe  <= 1'b1;
    end else begin
      state <= state_next;

      if (shifting && (state_next != ST_DONE)) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end

      // The shadow is consumed from bit 0 upward, one bit per shift cycle.
      if ((state == ST_IDLE) && host.start) begin
        shadow <= host.tx_data;
      end else if (state_next == ST_SHIFT) begin
        shadow <= shadow >> 1;
      end

      fake_en  <= (state_next == ST_SHIFT);
      fake_oe  <= (state_next != ST_SNAP);
      fake_din <= (state_next == ST_SHIFT) && shadow[0];
    end
  end

  phy_scan_master_capture #(
    .IN_LEN(IN_LEN)
  ) u_capture (
    .mclk      (mclk),
    .rst_in    (rst_in),
    .sample_en (sample_en),
    .sdin      (fake_dout),
    .commit    (commit),
    .rx_data   (rx_q)
  );

endmodule

// File: tb/tb_phy_scan_master.sv
// tb/tb_phy_scan_master.sv - Directed self-checking bench for phy_scan_master
module tb_phy_scan_master;
  import phy_scan_master_pkg::*;

  logic mclk;
  logic rst_in;
  int   errors = 0;
  int   checks = 0;

  // DUT A: 8/4/1, DUT B: 4/4/2, DUT C: full-size defaults
  logic a_din, a_en, a_oe, a_dout, a_dly;
  logic [7:0] a_load;
  logic [3:0] a_cap, snap_a;
  logic b_din, b_en, b_oe, b_dout, b_d1, b_d2;
  logic [3:0] b_load, b_cap, snap_b;
  logic c_din, c_en, c_oe, c_dout, c_dly;
  logic [DEF_OUT_LEN-1:0] c_load, tx_c;
  logic [DEF_IN_LEN-1:0]  c_cap, snap_c;

  phy_scan_master_if #(.OUT_LEN(8), .IN_LEN(4)) ifa ();
  phy_scan_master_if #(.OUT_LEN(4), .IN_LEN(4)) ifb ();
  phy_scan_master_if ifc ();

  phy_scan_master #(.OUT_LEN(8), .IN_LEN(4), .CAP_DELAY(1)) dut_a (
    .mclk(mclk), .rst_in(rst_in), .host(ifa),
    .fake_din(a_din), .fake_en(a_en), .fake_oe(a_oe), .fake_dout(a_dout));

  phy_scan_master #(.OUT_LEN(4), .IN_LEN(4), .CAP_DELAY(2)) dut_b (
    .mclk(mclk), .rst_in(rst_in), .host(ifb),
    .fake_din(b_din), .fake_en(b_en), .fake_oe(b_oe), .fake_dout(b_dout));

  phy_scan_master dut_c (
    .mclk(mclk), .rst_in(rst_in), .host(ifc),
    .fake_din(c_din), .fake_en(c_en), .fake_oe(c_oe), .fake_dout(c_dout));

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Target models: load chain shifts in LSB-first on fake_en; capture chain
  // snapshots on fake_oe=0, otherwise shifts MSB-first through CAP_DELAY flops.
  always @(posedge mclk) begin
    if (a_en) a_load <= {a_din, a_load[7:1]};
    a_cap <= a_oe ? (a_cap << 1) : snap_a;
    a_dly <= a_cap[3];
    if (b_en) b_load <= {b_din, b_load[3:1]};
    b_cap <= b_oe ? (b_cap << 1) : snap_b;
    b_d1  <= b_cap[3];
    b_d2  <= b_d1;
    if (c_en) c_load <= {c_din, c_load[DEF_OUT_LEN-1:1]};
    c_cap <= c_oe ? (c_cap << 1) : snap_c;
    c_dly <= c_cap[DEF_IN_LEN-1];
  end
  assign a_dout = a_dly;
  assign b_dout = b_d2;
  assign c_dout = c_dly;

  // One transaction on DUT A; cycle 1 is the first cycle after the accept edge.
  task automatic run_a(input logic [7:0] tx, output int done_cyc, output logic [7:0] bits,
                       output int en_cnt, output int snap_cnt, output int drain_cnt,
                       output logic [3:0] rx);
    bit seen;
    done_cyc = -1; bits = '0; en_cnt = 0; snap_cnt = 0; drain_cnt = 0; rx = '0; seen = 0;
    @(negedge mclk);
    ifa.start = 1'b1; ifa.tx_data = tx;
    for (int n = 1; n <= 40 && done_cyc < 0; n++) begin
      @(negedge mclk);
      if (n == 1) ifa.start = 1'b0;
      if (n == 3) ifa.tx_data = ~tx;
      if (a_en) begin
        if (en_cnt < 8) bits[en_cnt] = a_din;
        en_cnt++; seen = 1;
      end
      if (!a_oe) snap_cnt++;
      if (seen && !a_en && a_oe && !ifa.ready && !ifa.done) drain_cnt++;
      if (ifa.done) begin done_cyc = n; rx = ifa.rx_data; end
    end
  endtask

  task automatic test_reset;
    bit got;
    rst_in = 1'b0;
    repeat (2) @(negedge mclk);
    checks++; if (ifa.ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b want=1", ifa.ready); end
    checks++; if (ifa.done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b want=0", ifa.done); end
    checks++; if (a_en !== 1'b0) begin errors++; $display("FAIL rst_fake_en got=%b want=0", a_en); end
    checks++; if (a_oe !== 1'b1) begin errors++; $display("FAIL rst_fake_oe got=%b want=1", a_oe); end
    checks++; if (a_din !== 1'b0) begin errors++; $display("FAIL rst_fake_din got=%b want=0", a_din); end
    checks++; if (ifa.rx_data !== 4'h0) begin errors++; $display("FAIL rst_rx_a got=%h want=0", ifa.rx_data); end
    checks++; if (ifc.rx_data !== '0) begin errors++; $display("FAIL rst_rx_c got=%h want=0", ifc.rx_data); end
    // Release with start already high: the very first edge must accept.
    snap_a = 4'h2; ifa.tx_data = 8'h3C; ifa.start = 1'b1; rst_in = 1'b1;
    @(negedge mclk);
    ifa.start = 1'b0;
    checks++; if (a_oe !== 1'b0) begin errors++; $display("FAIL first_edge_snap got=%b want=0", a_oe); end
    checks++; if (ifa.ready !== 1'b0) begin errors++; $display("FAIL first_edge_ready got=%b want=0", ifa.ready); end
    got = 0;
    for (int n = 2; n <= 20 && !got; n++) begin
      @(negedge mclk);
      if (ifa.done) begin
        got = 1;
        checks++; if (n !== 10) begin errors++; $display("FAIL first_txn_latency got=%0d want=10", n); end
        checks++; if (ifa.rx_data !== 4'h2) begin errors++; $display("FAIL first_txn_rx got=%h want=2", ifa.rx_data); end
        checks++; if (a_load !== 8'h3C) begin errors++; $display("FAIL first_txn_load got=%h want=3c", a_load); end
      end
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL first_txn_timeout got=%b want=1", got); end
  endtask

  task automatic test_load_capture;
    logic [7:0] txv [2] = '{8'hA5, 8'h96};
    logic [3:0] snv [2] = '{4'b1101, 4'h7};
    int dc, en, sn, dr;
    logic [7:0] bits;
    logic [3:0] rx;
    for (int i = 0; i < 2; i++) begin
      snap_a = snv[i];
      run_a(txv[i], dc, bits, en, sn, dr, rx);
      checks++; if (dc !== 10) begin errors++; $display("FAIL lc%0d_latency got=%0d want=10", i, dc); end
      checks++; if (bits !== txv[i]) begin errors++; $display("FAIL lc%0d_din_seq got=%h want=%h", i, bits, txv[i]); end
      checks++; if (en !== 8) begin errors++; $display("FAIL lc%0d_en_cycles got=%0d want=8", i, en); end
      checks++; if (sn !== 1) begin errors++; $display("FAIL lc%0d_snap_cycles got=%0d want=1", i, sn); end
      checks++; if (dr !== 0) begin errors++; $display("FAIL lc%0d_drain got=%0d want=0", i, dr); end
      checks++; if (rx !== snv[i]) begin errors++; $display("FAIL lc%0d_rx got=%h want=%h", i, rx, snv[i]); end
      checks++; if (a_load !== txv[i]) begin errors++; $display("FAIL lc%0d_load got=%h want=%h", i, a_load, txv[i]); end
      @(negedge mclk);
      checks++; if (ifa.ready !== 1'b1) begin errors++; $display("FAIL lc%0d_ready_after got=%b want=1", i, ifa.ready); end
      checks++; if (ifa.rx_data !== snv[i]) begin errors++; $display("FAIL lc%0d_rx_hold got=%h want=%h", i, ifa.rx_data, snv[i]); end
    end
  endtask

  task automatic test_drain;
    int dc, en, dr;
    bit seen;
    logic [3:0] rx;
    dc = -1; en = 0; dr = 0; seen = 0; rx = '0;
    snap_b = 4'hB;
    @(negedge mclk);
    ifb.start = 1'b1; ifb.tx_data = 4'h6;
    for (int n = 1; n <= 30 && dc < 0; n++) begin
      @(negedge mclk);
      if (n == 1) ifb.start = 1'b0;
      if (n == 2) ifb.tx_data = 4'h9;
      if (b_en) begin en++; seen = 1; end
      if (seen && !b_en && b_oe && !ifb.ready && !ifb.done) dr++;
      if (ifb.done) begin dc = n; rx = ifb.rx_data; end
    end
    checks++; if (dc !== 8) begin errors++; $display("FAIL drain_latency got=%0d want=8", dc); end
    checks++; if (en !== 4) begin errors++; $display("FAIL drain_en_cycles got=%0d want=4", en); end
    checks++; if (dr !== 2) begin errors++; $display("FAIL drain_cycles got=%0d want=2", dr); end
    checks++; if (rx !== 4'hB) begin errors++; $display("FAIL drain_rx got=%h want=b", rx); end
    checks++; if (b_load !== 4'h6) begin errors++; $display("FAIL drain_load got=%h want=6", b_load); end
    @(negedge mclk);
    checks++; if (ifb.ready !== 1'b1) begin errors++; $display("FAIL drain_ready_after got=%b want=1", ifb.ready); end
  endtask

  task automatic test_back_to_back;
    int dn, d1, d2, rdy, e0, e1;
    logic [7:0] bits0, bits1;
    logic [3:0] rx0, rx1;
    dn = 0; d1 = -1; d2 = -1; rdy = 0; e0 = 0; e1 = 0;
    bits0 = '0; bits1 = '0; rx0 = '0; rx1 = '0;
    snap_a = 4'hA;
    @(negedge mclk);
    ifa.start = 1'b1; ifa.tx_data = 8'h81;
    for (int n = 1; n <= 60 && dn < 2; n++) begin
      @(negedge mclk);
      if (n == 4) ifa.tx_data = 8'h7E;
      if (a_en && dn == 0 && e0 < 8) begin bits0[e0] = a_din; e0++; end
      if (a_en && dn == 1 && e1 < 8) begin bits1[e1] = a_din; e1++; end
      if (ifa.ready && dn == 1) rdy++;
      if (ifa.done) begin
        dn++;
        if (dn == 1) begin d1 = n; rx0 = ifa.rx_data; end
        else begin d2 = n; rx1 = ifa.rx_data; ifa.start = 1'b0; end
      end
    end
    checks++; if (d1 !== 10) begin errors++; $display("FAIL b2b_done1 got=%0d want=10", d1); end
    checks++; if (d2 !== 21) begin errors++; $display("FAIL b2b_done2 got=%0d want=21", d2); end
    checks++; if (rdy !== 1) begin errors++; $display("FAIL b2b_ready_gap got=%0d want=1", rdy); end
    checks++; if (bits0 !== 8'h81) begin errors++; $display("FAIL b2b_din0 got=%h want=81", bits0); end
    checks++; if (bits1 !== 8'h7E) begin errors++; $display("FAIL b2b_din1 got=%h want=7e", bits1); end
    checks++; if (rx0 !== 4'hA || rx1 !== 4'hA) begin errors++; $display("FAIL b2b_rx got=%h/%h want=a/a", rx0, rx1); end
    @(negedge mclk);
    @(negedge mclk);
    checks++; if (ifa.ready !== 1'b1 || a_oe !== 1'b1) begin errors++; $display("FAIL b2b_no_third got=%b/%b want=1/1", ifa.ready, a_oe); end
  endtask

  task automatic test_reset_abort;
    int en, dc, sn, dr;
    bit hit, saw_done;
    logic [7:0] bits;
    logic [3:0] rx;
    en = 0; hit = 0; saw_done = 0;
    snap_a = 4'h9;
    @(negedge mclk);
    ifa.start = 1'b1; ifa.tx_data = 8'hF0;
    for (int n = 1; n <= 20 && !hit; n++) begin
      @(negedge mclk);
      if (n == 1) ifa.start = 1'b0;
      if (a_en) begin
        if (en == 3) begin
          hit = 1;
          rst_in = 1'b0;
          #1;
          checks++; if (a_en !== 1'b0) begin errors++; $display("FAIL abort_fake_en got=%b want=0", a_en); end
          checks++; if (a_oe !== 1'b1) begin errors++; $display("FAIL abort_fake_oe got=%b want=1", a_oe); end
          checks++; if (ifa.ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b want=1", ifa.ready); end
        end
        en++;
      end
    end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL abort_reach_shift3 got=%b want=1", hit); end
    repeat (3) begin
      @(negedge mclk);
      if (ifa.done) saw_done = 1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got=%b want=0", saw_done); end
    checks++; if (ifa.rx_data !== 4'h0) begin errors++; $display("FAIL abort_rx_cleared got=%h want=0", ifa.rx_data); end
    rst_in = 1'b1;
    snap_a = 4'h6;
    run_a(8'h5A, dc, bits, en, sn, dr, rx);
    checks++; if (dc !== 10) begin errors++; $display("FAIL abort_retry_latency got=%0d want=10", dc); end
    checks++; if (bits !== 8'h5A) begin errors++; $display("FAIL abort_retry_din got=%h want=5a", bits); end
    checks++; if (rx !== 4'h6) begin errors++; $display("FAIL abort_retry_rx got=%h want=6", rx); end
    checks++; if (a_load !== 8'h5A) begin errors++; $display("FAIL abort_retry_load got=%h want=5a", a_load); end
  endtask

  task automatic test_full_size;
    int dc, en;
    logic [DEF_IN_LEN-1:0] rx;
    dc = -1; en = 0; rx = '0;
    tx_c   = 163'h4_0123456789ABCDEF_FEDCBA9876543210_A5A5C3C3;
    snap_c = {1'b1, 8'hC7, 64'h0F1E2D3C4B5A6978};
    @(negedge mclk);
    ifc.start = 1'b1; ifc.tx_data = tx_c;
    for (int n = 1; n <= 300 && dc < 0; n++) begin
      @(negedge mclk);
      if (n == 1) ifc.start = 1'b0;
      if (n == 5) ifc.tx_data = ~tx_c;
      if (c_en) en++;
      if (ifc.done) begin dc = n; rx = ifc.rx_data; end
    end
    checks++; if (dc !== 165) begin errors++; $display("FAIL full_latency got=%0d want=165", dc); end
    checks++; if (en !== 163) begin errors++; $display("FAIL full_en_cycles got=%0d want=163", en); end
    checks++; if (c_load !== tx_c) begin errors++; $display("FAIL full_load got=%h want=%h", c_load, tx_c); end
    checks++; if (rx !== snap_c) begin errors++; $display("FAIL full_rx got=%h want=%h", rx, snap_c); end
  endtask

  initial begin
    rst_in = 1'b0;
    ifa.start = 1'b0; ifa.tx_data = '0;
    ifb.start = 1'b0; ifb.tx_data = '0;
    ifc.start = 1'b0; ifc.tx_data = '0;
    snap_a = '0; snap_b = '0; snap_c = '0; tx_c = '0;
    test_reset();
    test_load_capture();
    test_drain();
    test_back_to_back();
    test_reset_abort();
    test_full_size();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
